// File: rtl/hilo_muldiv_pkg.sv
// Shared ALU op codes and divider FSM encodings for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;
  localparam int DATA_W = 32;
  localparam int STAGES = 32;

  localparam logic [4:0] ALU_SIGNED_MULT   = 5'd10;
  localparam logic [4:0] ALU_UNSIGNED_MULT = 5'd11;
  localparam logic [4:0] ALU_SIGNED_DIV    = 5'd12;
  localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'd13;
  localparam logic [4:0] ALU_MTHI          = 5'd14;
  localparam logic [4:0] ALU_MTLO          = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle on operand magnitudes,
// signs applied to the final quotient/remainder.
module div_core
  import hilo_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              sign,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  div_state_e        state;
  logic [4:0]        count;
  logic [DATA_W-1:0] quo_p0, rem_p0, dsr_p0;
  logic              neg_q, neg_r;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] quo_next, rem_next;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Remainder stays below the divisor, so the restored value always fits DATA_W bits.
  always_comb begin
    shifted = {rem_p0, quo_p0[DATA_W-1]};
    if (shifted >= {1'b0, dsr_p0}) begin
      rem_next = shifted[DATA_W-1:0] - dsr_p0;
      quo_next = {quo_p0[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = shifted[DATA_W-1:0];
      quo_next = {quo_p0[DATA_W-2:0], 1'b0};
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == RUN) && (count == 5'(STAGES - 1)) && !abort;
  assign quotient  = cond_neg(quo_next, neg_q);
  assign remainder = cond_neg(rem_next, neg_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      quo_p0 <= '0;
      rem_p0 <= '0;
      dsr_p0 <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= RUN;
          count  <= '0;
          quo_p0 <= cond_neg(dividend, sign & dividend[DATA_W-1]);
          dsr_p0 <= cond_neg(divisor, sign & divisor[DATA_W-1]);
          rem_p0 <= '0;
          neg_q  <= sign & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
          neg_r  <= sign & dividend[DATA_W-1];
        end
        RUN: if (abort) begin
          state <= IDLE;
        end else begin
          quo_p0 <= quo_next;
          rem_p0 <= rem_next;
          count  <= count + 5'd1;
          if (count == 5'(STAGES - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with single-cycle multiply, MTHI/MTLO and a 32-cycle divider.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [4:0]        alu_control,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  logic [DATA_W-1:0]          hi, lo, quo, rem;
  logic                       div_busy, div_done, done_p1;
  logic                       is_sdiv, is_div, idle, accept, start;
  logic signed [2*DATA_W-1:0] mul_a_s, mul_b_s, prod_s;
  logic [2*DATA_W-1:0]        prod_u;

  assign is_sdiv = (alu_control == ALU_SIGNED_DIV);
  assign is_div  = is_sdiv || (alu_control == ALU_UNSIGNED_DIV);
  // done_p1 marks the DONE cycle, where the still-presented DIV must not be re-accepted.
  assign idle    = !div_busy && !done_p1;
  assign accept  = en && !flush && idle;
  assign start   = accept && is_div && (src_b != '0);
  assign busy    = div_busy || start;

  assign mul_a_s = (2*DATA_W)'(signed'(src_a));
  assign mul_b_s = (2*DATA_W)'(signed'(src_b));
  assign prod_s  = mul_a_s * mul_b_s;
  assign prod_u  = (2*DATA_W)'(src_a) * (2*DATA_W)'(src_b);

  div_core u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (flush),
    .dividend  (src_a),
    .divisor   (src_b),
    .sign      (is_sdiv),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) done_p1 <= 1'b0;
    else     done_p1 <= div_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_done) begin
      hi <= rem;
      lo <= quo;
    end else if (accept) begin
      case (alu_control)
        ALU_SIGNED_MULT:   {hi, lo} <= prod_s;
        ALU_UNSIGNED_MULT: {hi, lo} <= prod_u;
        ALU_MTHI:          hi <= src_a;
        ALU_MTLO:          lo <= src_a;
        default:           ;
      endcase
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized bench for hilo_muldiv against an arithmetic HI/LO reference model.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [4:0]  alu_control;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi_o, lo_o;

  logic [31:0] m_hi, m_lo;
  int n_cmp = 0;
  int n_err = 0;

  hilo_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .flush       (flush),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_div_op(input logic [4:0] op);
    return (op == ALU_SIGNED_DIV) || (op == ALU_UNSIGNED_DIV);
  endfunction

  // Architectural effect of one accepted instruction on HI/LO.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi_in, input logic [31:0] lo_in,
                       output logic [31:0] hi_out, output logic [31:0] lo_out);
    longint sa, sb;
    logic [63:0] p;
    hi_out = hi_in;
    lo_out = lo_in;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      ALU_SIGNED_MULT:   begin p = 64'(sa * sb); hi_out = p[63:32]; lo_out = p[31:0]; end
      ALU_UNSIGNED_MULT: begin p = {32'b0, a} * {32'b0, b}; hi_out = p[63:32]; lo_out = p[31:0]; end
      ALU_SIGNED_DIV:    if (b != 0) begin lo_out = 32'(sa / sb); hi_out = 32'(sa % sb); end
      ALU_UNSIGNED_DIV:  if (b != 0) begin lo_out = a / b; hi_out = a % b; end
      ALU_MTHI:          hi_out = a;
      ALU_MTLO:          lo_out = a;
      default:           ;
    endcase
  endtask

  // Issue one instruction, hold it while stalled; kill_at >= 0 asserts flush
  // (or rst when kill_rst) during that cycle offset from the accept cycle.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int kill_at, input bit kill_rst);
    logic [31:0] nh, nl, eh, el;
    bit dz, killed;
    int last;
    model(op, a, b, m_hi, m_lo, nh, nl);
    dz = is_div_op(op) && (b != 0);
    killed = (kill_at >= 0);
    if (killed && kill_at > 0) last = kill_at + 1;
    else if (killed)           last = 0;
    else                       last = dz ? 33 : 0;
    @(posedge clk); #1;
    en = 1'b1; alu_control = op; src_a = a; src_b = b;
    for (int c = 0; c <= last; c++) begin
      if (c == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else          flush = 1'b1;
      end
      @(negedge clk);
      check_eq("busy", 32'(busy), 32'(c < last));
      if (c == last) begin
        if (killed && kill_rst)  begin eh = 0;    el = 0;    end
        else if (killed || !dz)  begin eh = m_hi; el = m_lo; end
        else                     begin eh = nh;   el = nl;   end
        check_eq("hi_at_release", hi_o, eh);
        check_eq("lo_at_release", lo_o, el);
      end
      @(posedge clk); #1;
      if (c == kill_at) begin rst = 1'b0; flush = 1'b0; en = 1'b0; end
    end
    en = 1'b0;
    if (killed && kill_rst) begin m_hi = 0;  m_lo = 0;  end
    else if (!killed)       begin m_hi = nh; m_lo = nl; end
    @(negedge clk);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("hi_after", hi_o, m_hi);
    check_eq("lo_after", lo_o, m_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ops [8];
    logic [31:0] corner [6];
    logic [4:0]  op;
    logic [31:0] a, b;
    int k;
    ops[0] = ALU_SIGNED_MULT;  ops[1] = ALU_UNSIGNED_MULT;
    ops[2] = ALU_SIGNED_DIV;   ops[3] = ALU_UNSIGNED_DIV;
    ops[4] = ALU_MTHI;         ops[5] = ALU_MTLO;
    ops[6] = 5'd0;             ops[7] = 5'd3;
    corner[0] = 32'h0;        corner[1] = 32'h1;        corner[2] = 32'hFFFFFFFF;
    corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF; corner[5] = 32'd7;

    rst = 1'b1; en = 1'b0; flush = 1'b0; alu_control = '0; src_a = '0; src_b = '0;
    m_hi = 0; m_lo = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_hi", hi_o, 32'd0);
    check_eq("reset_lo", lo_o, 32'd0);

    run_op(ALU_UNSIGNED_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
    check_eq("multu_hi", hi_o, 32'hFFFFFFFE);
    check_eq("multu_lo", lo_o, 32'h00000001);

    run_op(ALU_SIGNED_DIV, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
    check_eq("div_m7_2_lo", lo_o, 32'hFFFFFFFD);
    check_eq("div_m7_2_hi", hi_o, 32'hFFFFFFFF);

    run_op(ALU_UNSIGNED_DIV, 32'd100, 32'd0, -1, 1'b0);
    check_eq("divz_hi", hi_o, 32'hFFFFFFFF);
    check_eq("divz_lo", lo_o, 32'hFFFFFFFD);

    run_op(ALU_UNSIGNED_DIV, 32'd1000, 32'd7, 10, 1'b0);
    check_eq("flush_hi", hi_o, 32'hFFFFFFFF);
    run_op(ALU_UNSIGNED_DIV, 32'd1000, 32'd7, -1, 1'b0);
    check_eq("divu_lo", lo_o, 32'd142);
    check_eq("divu_hi", hi_o, 32'd6);

    run_op(ALU_UNSIGNED_DIV, 32'd1000, 32'd7, 5, 1'b1);

    run_op(ALU_MTHI, 32'h12345678, 32'd0, -1, 1'b0);
    check_eq("mthi", hi_o, 32'h12345678);
    run_op(ALU_MTLO, 32'h9ABCDEF0, 32'd0, -1, 1'b0);
    check_eq("mtlo", lo_o, 32'h9ABCDEF0);
    run_op(ALU_SIGNED_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    check_eq("ovf_hi", hi_o, 32'h0);
    check_eq("ovf_lo", lo_o, 32'h80000000);

    run_op(ALU_SIGNED_MULT, 32'hFFFFFFFE, 32'd3, 0, 1'b0);
    run_op(ALU_SIGNED_DIV, 32'd50, 32'd5, 0, 1'b0);
    run_op(ALU_SIGNED_MULT, 32'hFFFFFFFE, 32'd3, -1, 1'b0);
    check_eq("mult_neg_hi", hi_o, 32'hFFFFFFFF);
    check_eq("mult_neg_lo", lo_o, 32'hFFFFFFFA);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 31);
      k = -1;
      if (is_div_op(op) && b != 0 && $urandom_range(0, 4) == 0) k = $urandom_range(1, 32);
      else if ($urandom_range(0, 9) == 0) k = 0;
      run_op(op, a, b, k, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
